// File: rtl/bsg_cat_map_ctrl_if.sv
// rtl/bsg_cat_map_ctrl_if.sv - job handshake and pixel RAM request signals of the cat map sequencer
interface bsg_cat_map_ctrl_if #(
  parameter int dim_p        = 16,
  parameter int max_rounds_p = 255
);
  localparam int addr_width_lp  = $clog2(dim_p * dim_p);
  localparam int round_width_lp = $clog2(max_rounds_p + 1);

  logic [round_width_lp-1:0] rounds_i;
  logic                      v_i;
  logic                      ready_o;
  logic                      v_o;
  logic                      yumi_i;
  logic                      result_bank_o;
  logic                      stall_i;
  logic                      rd_v_o;
  logic [addr_width_lp-1:0]  rd_addr_o;
  logic                      rd_bank_o;
  logic                      wr_v_o;
  logic [addr_width_lp-1:0]  wr_addr_o;
  logic                      wr_bank_o;

  modport slave (
    input  rounds_i, v_i, yumi_i, stall_i,
    output ready_o, v_o, result_bank_o,
    output rd_v_o, rd_addr_o, rd_bank_o,
    output wr_v_o, wr_addr_o, wr_bank_o
  );

  modport master (
    output rounds_i, v_i, yumi_i, stall_i,
    input  ready_o, v_o, result_bank_o,
    input  rd_v_o, rd_addr_o, rd_bank_o,
    input  wr_v_o, wr_addr_o, wr_bank_o
  );
endinterface

// File: rtl/bsg_cat_map_ctrl.sv
// rtl/bsg_cat_map_ctrl.sv - Arnold cat map sequencer scanning an N x N image across two ping-pong banks
module bsg_cat_map_ctrl #(
  parameter int dim_p        = 16,
  parameter int max_rounds_p = 255
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bsg_cat_map_ctrl_if.slave   bus
);
  localparam int coord_width_lp = $clog2(dim_p);
  localparam int addr_width_lp  = $clog2(dim_p * dim_p);
  localparam int round_width_lp = $clog2(max_rounds_p + 1);
  localparam int sum_width_lp   = coord_width_lp + 2;

  localparam logic [coord_width_lp-1:0] last_coord_lp = coord_width_lp'(dim_p - 1);
  localparam logic [sum_width_lp-1:0]   dim_sum_lp    = sum_width_lp'(dim_p);
  localparam logic [round_width_lp-1:0] max_rounds_lp = round_width_lp'(max_rounds_p);
  localparam logic [round_width_lp-1:0] one_round_lp  = round_width_lp'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                    r_state, w_state_n;
  logic [coord_width_lp-1:0] r_x, r_y, w_x_n, w_y_n;
  logic                      r_src, w_src_n;
  logic [round_width_lp-1:0] r_rounds, w_rounds_n, w_rounds_sat;
  logic                      w_rd_v;
  logic [addr_width_lp-1:0]  w_rd_addr, w_wr_addr;

  logic                      r_wr_v;
  logic [addr_width_lp-1:0]  r_wr_addr;
  logic                      r_wr_bank;

  logic [sum_width_lp-1:0]   w_sum_x, w_sum_y, w_sum_y1;
  logic [coord_width_lp-1:0] w_xp, w_yp;

  assign w_rounds_sat = (bus.rounds_i > max_rounds_lp) ? max_rounds_lp : bus.rounds_i;

  // x+y < 2N and x+2y < 3N, so conditional subtracts replace a general modulo
  assign w_sum_x  = sum_width_lp'(r_x) + sum_width_lp'(r_y);
  assign w_sum_y  = sum_width_lp'(r_x) + sum_width_lp'({r_y, 1'b0});
  assign w_sum_y1 = (w_sum_y >= dim_sum_lp) ? (w_sum_y - dim_sum_lp) : w_sum_y;
  assign w_xp     = coord_width_lp'((w_sum_x >= dim_sum_lp) ? (w_sum_x - dim_sum_lp) : w_sum_x);
  assign w_yp     = coord_width_lp'((w_sum_y1 >= dim_sum_lp) ? (w_sum_y1 - dim_sum_lp) : w_sum_y1);

  assign w_rd_addr = addr_width_lp'(r_y) * addr_width_lp'(dim_p) + addr_width_lp'(r_x);
  assign w_wr_addr = addr_width_lp'(w_yp) * addr_width_lp'(dim_p) + addr_width_lp'(w_xp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_x_n      = r_x;
    w_y_n      = r_y;
    w_src_n    = r_src;
    w_rounds_n = r_rounds;
    w_rd_v     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.v_i) begin
          w_rounds_n = w_rounds_sat;
          w_src_n    = 1'b0;
          w_x_n      = '0;
          w_y_n      = '0;
          w_state_n  = (w_rounds_sat == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!bus.stall_i) begin
          w_rd_v = 1'b1;
          if (r_x == last_coord_lp) begin
            w_x_n = '0;
            if (r_y == last_coord_lp) begin
              w_y_n     = '0;
              w_state_n = DRAIN;
            end else begin
              w_y_n = r_y + 1'b1;
            end
          end else begin
            w_x_n = r_x + 1'b1;
          end
        end
      end
      // one-cycle bubble so the next round never reads the bank still taking its last write
      DRAIN: begin
        w_rounds_n = r_rounds - one_round_lp;
        w_src_n    = ~r_src;
        w_state_n  = (r_rounds == one_round_lp) ? DONE : RUN;
      end
      DONE: begin
        if (bus.yumi_i) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_x       <= '0;
      r_y       <= '0;
      r_src     <= 1'b0;
      r_rounds  <= '0;
      r_wr_v    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_bank <= 1'b0;
    end else begin
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_src     <= w_src_n;
      r_rounds  <= w_rounds_n;
      r_wr_v    <= w_rd_v;
      r_wr_addr <= w_rd_v ? w_wr_addr : '0;
      r_wr_bank <= w_rd_v & ~r_src;
    end
  end

  assign bus.ready_o       = (r_state == IDLE);
  assign bus.v_o           = (r_state == DONE);
  assign bus.result_bank_o = (r_state == DONE) & r_src;
  assign bus.rd_v_o        = w_rd_v;
  assign bus.rd_addr_o     = w_rd_v ? w_rd_addr : '0;
  assign bus.rd_bank_o     = w_rd_v & r_src;
  assign bus.wr_v_o        = r_wr_v;
  assign bus.wr_addr_o     = r_wr_addr;
  assign bus.wr_bank_o     = r_wr_bank;
endmodule
